// File: rtl/conv_sequencer.sv
// Sequencer for the 1-D convolution engine: gates the loader write phase, walks
// the sliding-window read addresses, drives the accumulator and hands out Y[n].
module conv_sequencer #(
    parameter int INPUT_N     = 16,
    parameter int LG_INPUT_N  = 4,
    parameter int FILTER_N    = 8,
    parameter int LG_FILTER_N = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   done_x,
    input  logic                   done_f,
    output logic                   mem_wr_state,
    output logic                   mem_wr_done,
    output logic [LG_INPUT_N-1:0]  rd_addr_x,
    output logic [LG_FILTER_N-1:0] rd_addr_f,
    output logic                   acc_en,
    output logic                   acc_clr,
    output logic                   m_valid_y,
    input  logic                   m_ready_y
);
    localparam int NUM_Y = INPUT_N - FILTER_N + 1;

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic [LG_INPUT_N-1:0]  N_LAST = LG_INPUT_N'(NUM_Y - 1);
    localparam logic [LG_FILTER_N-1:0] K_LAST = LG_FILTER_N'(FILTER_N - 1);

    logic [1:0]             state, state_nxt;
    logic [LG_INPUT_N-1:0]  n;
    logic [LG_FILTER_N-1:0] k;
    logic                   both_done, out_fire, last_k, last_n;

    assign both_done = done_x & done_f;
    assign out_fire  = (state == S_OUT) & m_ready_y;
    assign last_k    = (k == K_LAST);
    assign last_n    = (n == N_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:  if (both_done) state_nxt = S_MAC;
            S_MAC:   if (last_k) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_OUT;
            S_OUT:   if (m_ready_y) state_nxt = last_n ? S_LOAD : S_MAC;
            default: state_nxt = S_LOAD;
        endcase
    end

    // acc_en/acc_clr lag the tap issue by one cycle to line up with memory read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_LOAD;
            n       <= '0;
            k       <= '0;
            acc_en  <= 1'b0;
            acc_clr <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc_en  <= (state == S_MAC);
            acc_clr <= (state == S_MAC) && (k == '0);
            if (state == S_LOAD) begin
                n <= '0;
                k <= '0;
            end
            if (state == S_MAC)
                k <= last_k ? '0 : k + 1'b1;
            if (out_fire)
                n <= last_n ? '0 : n + 1'b1;
        end
    end

    assign rd_addr_x    = n + LG_INPUT_N'(k);
    assign rd_addr_f    = k;
    assign mem_wr_state = (state == S_LOAD);
    assign m_valid_y    = (state == S_OUT);
    assign mem_wr_done  = out_fire & last_n;

endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Top-level sequencer for the 1-D convolution engine. While the X and F loader controls fill their memories, it holds the write phase open. Once both report done, it walks the sliding-window read addresses and drives the MAC accumulator's enable/clear. It then presents each result Y[n] on a valid/ready output handshake. After the last output is accepted, it pulses `mem_wr_done` to rewind the loaders and reopens the write phase for the next vector pair.

## Interface
Parameters:
- `INPUT_N`, default 16: X vector length; must be a power of 2.
- `LG_INPUT_N`, default 4: log2(INPUT_N).
- `FILTER_N`, default 8: F vector length; power of 2, ≤ INPUT_N.
- `LG_FILTER_N`, default 3: log2(FILTER_N).
- Derived `NUM_Y` = INPUT_N − FILTER_N + 1 (default 9).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `done_x` in 1: X memory full; level, held until `mem_wr_done`.
- `done_f` in 1: F memory full; level, held until `mem_wr_done`.
- `mem_wr_state` out 1: write phase open; loaders may accept data.
- `mem_wr_done` out 1: one-cycle pulse; loaders rewind to address 0.
- `rd_addr_x` out LG_INPUT_N: X memory read address.
- `rd_addr_f` out LG_FILTER_N: F memory read address.
- `acc_en` out 1: accumulator updates with the current product.
- `acc_clr` out 1: with `acc_en`, accumulator loads the product instead of adding it.
- `m_valid_y` out 1: accumulator holds a valid Y[n].
- `m_ready_y` in 1: downstream accepts Y[n].

## Operation
- Counters:
  - `n` (output index, LG_INPUT_N bits, range 0..NUM_Y−1).
  - `k` (tap index, LG_FILTER_N bits, range 0..FILTER_N−1).
  - Both are 0 at reset.
- `rd_addr_x` = n + k, `rd_addr_f` = k, both combinational from the counters. n + k ≤ INPUT_N−1, so the sum never overflows.
- FSM states: LOAD, MAC, DRAIN, OUT. Reset state is LOAD.
- LOAD:
  - `mem_wr_state` = 1.
  - When `done_x & done_f` are both high in the same cycle, go to MAC with n = 0, k = 0.
  - If the two dones rise in different cycles, the FSM waits; both are level signals.
- MAC:
  - Issues one tap per cycle; k increments every cycle.
  - At k = FILTER_N−1, go to DRAIN and set k to 0.
- DRAIN: one cycle. Lets the last tap's product reach the accumulator, then go to OUT.
- OUT:
  - `m_valid_y` = 1 and is held until `m_ready_y`.
  - On handshake with n < NUM_Y−1: n++ and go to MAC.
  - On handshake with n = NUM_Y−1: `mem_wr_done` = 1 combinationally in that same cycle, n goes to 0, FSM goes to LOAD.
- `acc_en` is registered: it equals 1 in the cycle after each MAC cycle. This matches the 1-cycle memory read latency.
- `acc_clr` is registered: it equals 1 in the cycle after the MAC cycle with k = 0.
- `done_x`/`done_f` are ignored outside LOAD. `m_ready_y` is ignored outside OUT.

## Timing
- Reset values:
  - `mem_wr_state` = 1.
  - `mem_wr_done` = 0, `acc_en` = 0, `acc_clr` = 0, `m_valid_y` = 0.
  - `rd_addr_x` = 0, `rd_addr_f` = 0.
- Reset asserted mid-MAC, mid-DRAIN or mid-OUT returns the FSM to LOAD immediately. Pending outputs are discarded and the counters clear.
- Cycle numbering, with cycle 0 the first MAC cycle:
  - Taps are issued in cycles 0..FILTER_N−1.
  - `acc_en` is high in cycles 1..FILTER_N; `acc_clr` is high in cycle 1 only.
  - DRAIN is cycle FILTER_N.
  - `m_valid_y` rises in cycle FILTER_N+1.
- Per-output cost is FILTER_N+2 cycles when `m_ready_y` is held high (10 cycles by default).
- A full pass costs NUM_Y·(FILTER_N+2) cycles (90 by default).
- LOAD → MAC takes 1 cycle after both dones are seen high.
- `mem_wr_state` deasserts in the first MAC cycle. It reasserts in the cycle after the `mem_wr_done` pulse.
- FILTER_N = INPUT_N gives NUM_Y = 1: one output per pass, and `mem_wr_done` is asserted on the first OUT handshake.

## Test plan
- Address sweep (defaults):
  - Raise `done_x` and `done_f` together with `m_ready_y` held at 1.
  - Output 0: `rd_addr_x` = 0..7 and `rd_addr_f` = 0..7 in cycles 0..7; `m_valid_y` high in cycle 9.
  - Output 1: `rd_addr_x` = 1..8.
  - Output 8: `rd_addr_x` = 8..15.
- End-to-end with a memory+MAC model: X = 0..15, F = all 1 → Y[n] = 8n + 28 for n = 0..8.
  - `mem_wr_done` pulses exactly once, in the same cycle as the Y[8] handshake.
  - `mem_wr_state` is high again in the next cycle.
- Staggered done: `done_f` at cycle 3, `done_x` at cycle 10 → the FSM stays in LOAD until both are high, and the first MAC cycle is cycle 11.
- Backpressure: hold `m_ready_y` = 0 for 5 cycles during OUT of Y[2].
  - `m_valid_y` stays high, and `rd_addr_x`/`acc_en` stay constant.
  - Y[3]'s taps start the cycle after the handshake.
- Reset mid-MAC (k = 4, n = 3):
  - All outputs take their reset values in the same cycle as reset.
  - After reset is released, the FSM sits in LOAD and a full correct pass follows.
- Corner configuration: INPUT_N = FILTER_N = 8 → one output, 10 cycles per pass, `mem_wr_done` on the first handshake.
